// File: rtl/piso_shift_out.sv
// piso_shift_out: parallel-in serial-out shifter with a READY/LOAD handshake.
// A word accepted on a load edge is streamed one bit per clock on Q. During the
// last bit READY is raised again so the next word can follow with no idle cycle.
module piso_shift_out #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             LOAD,
    output logic             READY,
    output logic             Q,
    output logic             Q_VALID,
    output logic             DONE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               busy;
    logic               last_bit;
    logic [WIDTH-1:0]   shifted;

    // Output decodes: every output depends on registered state only, never on LOAD or D_IN.
    always_comb begin
        busy     = (state_q == SHIFT);
        last_bit = busy && (cnt_q == LAST_CNT);
        READY    = !busy || last_bit;
        Q_VALID  = busy;
        DONE     = last_bit;
        if (!busy) begin
            Q = 1'b0;
        end else if (MSB_FIRST != 0) begin
            Q = shift_reg_q[WIDTH-1];
        end else begin
            Q = shift_reg_q[0];
        end
    end

    // Next-state logic: accept a word when ready, otherwise advance the shift by one bit.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        cnt_d       = cnt_q;

        if (MSB_FIRST != 0) begin
            shifted = {shift_reg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shift_reg_q[WIDTH-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    shift_reg_d = D_IN;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (LOAD) begin
                        // Back-to-back word: reload without leaving SHIFT.
                        shift_reg_d = D_IN;
                        cnt_d       = '0;
                    end else begin
                        shift_reg_d = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end else begin
                    // Mid-word: LOAD and D_IN are ignored.
                    shift_reg_d = shifted;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                shift_reg_d = '0;
                cnt_d       = '0;
            end
        endcase
    end

    // State registers: asynchronous reset drops any word in flight and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments; the combinational blocks above use blocking.
        if (rst) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_out.sv
// Directed testbench for piso_shift_out. Two instances share all inputs:
// u_msb streams MSB first, u_lsb streams LSB first. Expected streams are
// hand-written literals whose bit 7 is the first bit on Q.
module tb_piso_shift_out;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_in;
    logic       load;

    logic ready0, q0, qv0, done0;
    logic ready1, q1, qv1, done1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_shift_out #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .D_IN(d_in), .LOAD(load),
        .READY(ready0), .Q(q0), .Q_VALID(qv0), .DONE(done0)
    );

    piso_shift_out #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .D_IN(d_in), .LOAD(load),
        .READY(ready1), .Q(q1), .Q_VALID(qv1), .DONE(done1)
    );

    task automatic check(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both instances idle (or held in reset).
    task automatic check_idle(input string tag);
        check({tag, ".ready0"}, ready0, 1'b1);
        check({tag, ".q0"},     q0,     1'b0);
        check({tag, ".qv0"},    qv0,    1'b0);
        check({tag, ".done0"},  done0,  1'b0);
        check({tag, ".ready1"}, ready1, 1'b1);
        check({tag, ".q1"},     q1,     1'b0);
        check({tag, ".qv1"},    qv1,    1'b0);
        check({tag, ".done1"},  done1,  1'b0);
    endtask

    // Called in the first bit cycle of a word; returns in the last bit cycle.
    // s0/s1 are the expected streams of u_msb/u_lsb, first bit in bit 7.
    // At cycle pulse_at a busy LOAD pulse with D_IN=8'h0F is driven for one edge.
    task automatic check_word(input string tag, input logic [7:0] s0,
                              input logic [7:0] s1, input int pulse_at);
        for (int k = 0; k < 8; k++) begin
            string t;
            t = $sformatf("%s[%0d]", tag, k);
            if (k == pulse_at) begin
                load = 1'b1;
                d_in = 8'h0F;
                #1;
            end
            check({t, ".q0"},     q0,     s0[7-k]);
            check({t, ".q1"},     q1,     s1[7-k]);
            check({t, ".qv0"},    qv0,    1'b1);
            check({t, ".qv1"},    qv1,    1'b1);
            check({t, ".done0"},  done0,  k == 7);
            check({t, ".done1"},  done1,  k == 7);
            check({t, ".ready0"}, ready0, k == 7);
            check({t, ".ready1"}, ready1, k == 7);
            if (k < 7) begin
                step();
                if (k == pulse_at) load = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset asserted from time zero.
        rst  = 1'b1;
        load = 1'b0;
        d_in = 8'h00;
        #1;
        check_idle("reset_t0");
        step();
        step();
        rst = 1'b0;
        step();
        check_idle("idle_after_release");

        // MSB first 1D -> 0,0,0,1,1,1,0,1 ; LSB first 1D -> 1,0,1,1,1,0,0,0.
        load = 1'b1;
        d_in = 8'h1D;
        step();
        load = 1'b0;
        d_in = 8'hC3;
        check_word("w1D", 8'b0001_1101, 8'b1011_1000, -1);
        step();
        check_idle("idle_after_1D");

        // Back-to-back: FF then 00 with LOAD held high, 16 contiguous valid cycles.
        load = 1'b1;
        d_in = 8'hFF;
        step();
        check_word("b2b_FF", 8'hFF, 8'hFF, -1);
        d_in = 8'h00;
        step();
        check_word("b2b_00", 8'h00, 8'h00, -1);
        load = 1'b0;
        step();
        check_idle("idle_after_b2b");

        // Busy load: LOAD pulse with 0F at CNT=3 during F0 must be ignored.
        load = 1'b1;
        d_in = 8'hF0;
        step();
        load = 1'b0;
        check_word("busy_F0", 8'b1111_0000, 8'b0000_1111, 3);
        step();
        check_idle("idle_after_busy");

        // Reset mid-word: load AA, three bits out, then async reset mid-cycle.
        load = 1'b1;
        d_in = 8'hAA;
        step();
        load = 1'b0;
        check("rst_mid[0].q0", q0, 1'b1);
        check("rst_mid[0].q1", q1, 1'b0);
        step();
        check("rst_mid[1].q0", q0, 1'b0);
        check("rst_mid[1].q1", q1, 1'b1);
        step();
        check("rst_mid[2].q0", q0, 1'b1);
        check("rst_mid[2].q1", q1, 1'b0);
        step();
        check("rst_mid[3].qv0", qv0, 1'b1);
        #3;
        rst  = 1'b1;
        load = 1'b1;
        d_in = 8'hFF;
        #1;
        check_idle("rst_async");
        // Edges with rst=1 accept no load.
        step();
        step();
        check_idle("rst_held_load");
        rst  = 1'b0;
        load = 1'b0;
        step();
        check_idle("idle_after_rst_mid");

        // Fresh word after reset: 81 -> 1,0,0,0,0,0,0,1 either order.
        load = 1'b1;
        d_in = 8'h81;
        step();
        load = 1'b0;
        check_word("w81", 8'h81, 8'h81, -1);
        step();
        check_idle("idle_after_81");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
